spi_mnrch_param: RTL

Parametrised SPI monarch (mode 3: SCLK idles high, MOSI launched on SCLK fall, MISO sampled on SCLK rise). It generalises the team's fixed 16-bit single-slave SPI monarch in four ways: configurable word width and SCLK divider, multiple slave selects, bit order, and SS hold for multi-word bursts. It sits between a host-side command/sensor controller and one or more SPI peripherals such as the inertial sensor.

---
 rtl/spi_mnrch_param.sv | 124 ++++++++++++
 1 files changed

// File: rtl/spi_mnrch_param.sv
// Parametrised mode-3 SPI monarch: configurable width, divider,
// slave selects, bit order and SS hold across multi-word bursts.
module spi_mnrch_param #(
  parameter int DATA_W     = 16,
  parameter int SCLK_DIV_W = 5,
  parameter int NUM_SS     = 1,
  parameter int LSB_FIRST  = 0,
  localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
  localparam int CNT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] wt_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              keep_ss,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE, FRONT, SHIFT, BACK, HOLD
  } state_t;

  // Preload leaves N/4 clk of high SCLK before the launch fall
  localparam logic [SCLK_DIV_W-1:0] PRE =
    {2'b11, {(SCLK_DIV_W-2){1'b0}}};
  localparam logic [SCLK_DIV_W-1:0] FALL = '1;
  localparam logic [SCLK_DIV_W-1:0] RISE =
    {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W-1);

  state_t st, nxt;
  logic [SCLK_DIV_W-1:0] div;
  logic [CNT_W-1:0] bit_cnt;
  logic [DATA_W-1:0] shft;
  logic miso_q, keep_q;
  logic ld, shift, samp, fin, run;
  logic in_range, fall, rise;

  assign in_range = int'({1'b0, ss_sel}) < NUM_SS;
  assign fall = (div == FALL);
  assign rise = (div == RISE);

  always_comb begin
    nxt   = st;
    ld    = 1'b0;
    shift = 1'b0;
    samp  = 1'b0;
    fin   = 1'b0;
    run   = 1'b0;
    unique case (st)
      IDLE: begin
        ld = wrt && in_range;
        if (ld) nxt = FRONT;
      end
      HOLD: begin
        ld = wrt;
        if (ld) nxt = FRONT;
      end
      FRONT: begin
        run = 1'b1;
        if (fall) nxt = SHIFT;
      end
      SHIFT: begin
        run = 1'b1;
        if (fall) shift = 1'b1;
        if (rise) begin
          samp = 1'b1;
          if (bit_cnt == LAST) nxt = BACK;
        end
      end
      BACK: begin
        run = 1'b1;
        if (fall) begin
          shift = 1'b1;
          fin   = 1'b1;
          nxt   = keep_q ? HOLD : IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      div     <= PRE;
      bit_cnt <= '0;
      shft    <= '0;
      miso_q  <= 1'b0;
      keep_q  <= 1'b0;
      SS_n    <= '1;
      done    <= 1'b0;
    end else begin
      st  <= nxt;
      div <= (run && !fin) ? div + 1'b1 : PRE;
      if (ld) bit_cnt <= '0;
      else if (samp) bit_cnt <= bit_cnt + 1'b1;
      if (ld) shft <= wt_data;
      else if (shift) begin
        if (LSB_FIRST != 0) shft <= {miso_q, shft[DATA_W-1:1]};
        else shft <= {shft[DATA_W-2:0], miso_q};
      end
      if (samp) miso_q <= MISO;
      if (ld) keep_q <= keep_ss;
      if (ld && st == IDLE) SS_n <= ~(NUM_SS'(1) << ss_sel);
      else if (fin && !keep_q) SS_n <= '1;
      if (ld) done <= 1'b0;
      else if (fin) done <= 1'b1;
    end
  end

  assign SCLK    = div[SCLK_DIV_W-1];
  assign MOSI    = (LSB_FIRST != 0) ? shft[0] : shft[DATA_W-1];
  assign busy    = (st == FRONT) || (st == SHIFT) || (st == BACK);
  assign rd_data = shft;

endmodule
